// File: rtl/run_ctrl_if.sv
// Program-load port from the host and the instruction-memory write strobe it produces.
// master = host/bench side, slave = run_ctrl.
interface run_ctrl_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               ld_valid;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: streams a program into imem, then gates cpu execution (run/step/stop/halt).
// Optional breakpoint support under `RUN_CTRL_BREAKPOINT_EN.
module run_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_load,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_stop,
  run_ctrl_if.slave         ld,
  input  logic [ADDR_W-1:0] pc,
  input  logic              is_halt,
  output logic              cpu_en,
  output logic              cpu_clear,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycle_cnt
`ifdef RUN_CTRL_BREAKPOINT_EN
  ,
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            st;
  logic [ADDR_W-1:0] ld_addr;
  logic [CNT_W-1:0]  cnt;
  logic              clr_q;
  logic              wr;
  logic              ld_done;
  logic              bp_stop;
  logic              en;

  // A beat coinciding with cmd_stop is consumed but never written.
  assign wr      = (st == S_LOAD) & ld.ld_valid & ~cmd_stop;
  assign ld_done = wr & (ld.ld_last | (ld_addr == '1));

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic run_first;
  // First RUN cycle skips the compare so a re-run can step off the breakpoint.
  assign bp_stop = (st == S_RUN) & bp_valid & (pc == bp_addr) & ~run_first
                   & ~is_halt & ~cmd_stop;
  assign bp_hit  = RST_N & bp_stop;
`else
  logic pc_unused;
  assign pc_unused = ^pc;
  assign bp_stop   = 1'b0;
`endif

  assign en = ((st == S_RUN) | (st == S_STEP)) & ~is_halt & ~cmd_stop & ~bp_stop;

  assign ld.ld_ready   = RST_N & (st == S_LOAD);
  assign ld.imem_we    = RST_N & wr;
  assign ld.imem_addr  = RST_N ? ld_addr : '0;
  assign ld.imem_wdata = RST_N ? ld.ld_data : '0;
  assign cpu_en        = RST_N & en;
  assign cpu_clear     = RST_N & clr_q;
  assign state         = RST_N ? st : S_IDLE;
  assign cycle_cnt     = RST_N ? cnt : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st      <= S_IDLE;
      ld_addr <= '0;
      cnt     <= '0;
      clr_q   <= 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
      run_first <= 1'b0;
`endif
    end else begin
      clr_q <= 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
      run_first <= 1'b0;
`endif
      if (clr_q)
        cnt <= '0;
      else if (en)
        cnt <= cnt + CNT_ONE;

      case (st)
        S_IDLE: begin
          if (cmd_stop) begin
            st <= S_IDLE;
          end else if (cmd_load) begin
            st      <= S_LOAD;
            ld_addr <= '0;
            cnt     <= '0;
          end else if (cmd_run) begin
            st <= S_RUN;
`ifdef RUN_CTRL_BREAKPOINT_EN
            run_first <= 1'b1;
`endif
          end else if (cmd_step) begin
            st <= S_STEP;
          end
        end
        S_LOAD: begin
          if (cmd_stop) begin
            st <= S_IDLE;
          end else if (wr) begin
            // Address saturates at the top of memory instead of wrapping.
            if (ld_addr != '1)
              ld_addr <= ld_addr + ADDR_ONE;
            if (ld_done) begin
              st    <= S_IDLE;
              clr_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cmd_stop)
            st <= S_IDLE;
          else if (is_halt)
            st <= S_HALTED;
          else if (bp_stop)
            st <= S_IDLE;
        end
        S_STEP: begin
          if (!cmd_stop && is_halt)
            st <= S_HALTED;
          else
            st <= S_IDLE;
        end
        S_HALTED: begin
          if (cmd_stop) begin
            st <= S_IDLE;
          end else if (cmd_load) begin
            st      <= S_LOAD;
            ld_addr <= '0;
            cnt     <= '0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: small cpu model (pc/imem/halt decode) plus hand-computed checks.
module tb_run_ctrl;
  localparam int AW = 16;
  localparam int IW = 16;
  localparam int CW = 32;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          cmd_load, cmd_run, cmd_step, cmd_stop;
  logic [AW-1:0] pc;
  logic          is_halt;
  logic          cpu_en, cpu_clear;
  logic [2:0]    state;
  logic [CW-1:0] cycle_cnt;
`ifdef RUN_CTRL_BREAKPOINT_EN
  logic          bp_valid;
  logic [AW-1:0] bp_addr;
  logic          bp_hit;
  int            bp_cnt = 0;
`endif

  always #5 CLK = ~CLK;

  run_ctrl_if #(.ADDR_W(AW), .INSTR_W(IW)) ld ();

  run_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .cmd_load  (cmd_load),
    .cmd_run   (cmd_run),
    .cmd_step  (cmd_step),
    .cmd_stop  (cmd_stop),
    .ld        (ld.slave),
    .pc        (pc),
    .is_halt   (is_halt),
    .cpu_en    (cpu_en),
    .cpu_clear (cpu_clear),
    .state     (state),
    .cycle_cnt (cycle_cnt)
`ifdef RUN_CTRL_BREAKPOINT_EN
    ,
    .bp_valid  (bp_valid),
    .bp_addr   (bp_addr),
    .bp_hit    (bp_hit)
`endif
  );

  // Minimal cpu: imem copy, pc advancing on cpu_en, halt opcode 0xF in the top nibble.
  logic [IW-1:0] mem [0:7] = '{default: '0};
  logic [AW-1:0] wr_addr [$];
  logic [IW-1:0] wr_data [$];
  int            clr_cnt  = 0;
  int            en_total = 0;

  assign is_halt = (mem[pc[2:0]][15:12] == 4'hF);

  always @(posedge CLK) begin
    if (ld.imem_we) begin
      wr_addr.push_back(ld.imem_addr);
      wr_data.push_back(ld.imem_wdata);
      if (ld.imem_addr < 16'd8) mem[ld.imem_addr[2:0]] <= ld.imem_wdata;
    end
    if (cpu_clear) clr_cnt++;
    if (cpu_en) en_total++;
`ifdef RUN_CTRL_BREAKPOINT_EN
    if (bp_hit) bp_cnt++;
`endif
    if (!RST_N || cpu_clear) pc <= '0;
    else if (cpu_en)         pc <= pc + 16'd1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  logic [IW-1:0] prog [4];

  task automatic do_load(input string tag);
    int clr0;
    int wr0;
    clr0 = clr_cnt;
    wr0  = wr_addr.size();
    cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
    #1 chk({tag, "_ready"}, 64'(ld.ld_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      ld.ld_valid = 1'b1;
      ld.ld_data  = prog[i];
      ld.ld_last  = (i == 3);
      #1;
      chk({tag, "_we"},   64'(ld.imem_we),   64'd1);
      chk({tag, "_addr"}, 64'(ld.imem_addr), 64'(i));
      cyc();
    end
    ld.ld_valid = 1'b0;
    ld.ld_last  = 1'b0;
    #1;
    chk({tag, "_clear"}, 64'(cpu_clear), 64'd1);
    chk({tag, "_idle"},  64'(state),     64'd0);
    cyc();
    #1;
    chk({tag, "_clear_off"}, 64'(cpu_clear), 64'd0);
    chk({tag, "_clr_pulses"}, 64'(clr_cnt - clr0), 64'd1);
    chk({tag, "_writes"}, 64'(wr_addr.size() - wr0), 64'd4);
    if (wr_addr.size() - wr0 == 4)
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_wa"}, 64'(wr_addr[wr0+i]), 64'(i));
        chk({tag, "_wd"}, 64'(wr_data[wr0+i]), 64'(prog[i]));
      end
  endtask

  int en0;
  int wr0;
  int clr0;

  initial begin
    RST_N = 1'b0;
    cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
    ld.ld_valid = 1'b0; ld.ld_data = '0; ld.ld_last = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    bp_valid = 1'b0; bp_addr = '0;
`endif
    prog[0] = 16'h1012; prog[1] = 16'h1123; prog[2] = 16'h0000; prog[3] = 16'hF000;
    cyc(); cyc();
    #1;
    chk("rst_state", 64'(state),       64'd0);
    chk("rst_en",    64'(cpu_en),      64'd0);
    chk("rst_cnt",   64'(cycle_cnt),   64'd0);
    chk("rst_ready", 64'(ld.ld_ready), 64'd0);
    RST_N = 1'b1;
    cyc();

    do_load("load1");

    // Free run until the halt opcode at address 3.
    en0 = en_total;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    for (int i = 0; i < 20 && state != 3'd4; i++) cyc();
    #1;
    chk("run_halted", 64'(state),           64'd4);
    chk("run_en_cyc", 64'(en_total - en0),  64'd3);
    chk("run_cnt",    64'(cycle_cnt),       64'd3);
    chk("run_pc",     64'(pc),              64'd3);
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    #1;
    chk("halt_run_ign", 64'(state),  64'd4);
    chk("halt_en",      64'(cpu_en), 64'd0);

    // Single-step from a fresh load.
    do_load("load2");
    chk("step_cnt0", 64'(cycle_cnt), 64'd0);
    for (int s = 0; s < 3; s++) begin
      cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
      #1 chk("step_en", 64'(cpu_en), 64'd1);
      cyc();
      #1;
      chk("step_en_off", 64'(cpu_en), 64'd0);
      chk("step_idle",   64'(state),  64'd0);
    end
    chk("step_cnt", 64'(cycle_cnt), 64'd3);
    chk("step_pc",  64'(pc),        64'd3);
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    #1 chk("step_halt_en", 64'(cpu_en), 64'd0);
    cyc();
    #1 chk("step_halted", 64'(state), 64'd4);

    // Load with gaps, aborted by cmd_stop after two beats.
    wr0  = wr_addr.size();
    clr0 = clr_cnt;
    cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
    ld.ld_valid = 1'b1; ld.ld_data = 16'h2AAA; cyc();
    ld.ld_valid = 1'b0; cyc();
    ld.ld_valid = 1'b1; ld.ld_data = 16'h2BBB; cyc();
    ld.ld_valid = 1'b0; cyc();
    ld.ld_valid = 1'b1; ld.ld_data = 16'h2CCC; cmd_stop = 1'b1;
    #1 chk("abort_we", 64'(ld.imem_we), 64'd0);
    cyc();
    ld.ld_valid = 1'b0; cmd_stop = 1'b0;
    #1;
    chk("abort_idle",  64'(state),     64'd0);
    chk("abort_clear", 64'(cpu_clear), 64'd0);
    cyc();
    chk("abort_nclr",   64'(clr_cnt - clr0),        64'd0);
    chk("abort_writes", 64'(wr_addr.size() - wr0), 64'd2);
    if (wr_addr.size() - wr0 == 2) begin
      chk("abort_a0", 64'(wr_addr[wr0]),   64'd0);
      chk("abort_d0", 64'(wr_data[wr0]),   64'h2AAA);
      chk("abort_a1", 64'(wr_addr[wr0+1]), 64'd1);
      chk("abort_d1", 64'(wr_data[wr0+1]), 64'h2BBB);
    end

    // Reset in the middle of a load.
    wr0 = wr_addr.size();
    cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
    ld.ld_valid = 1'b1; ld.ld_data = 16'h3333; RST_N = 1'b0;
    #1;
    chk("rstld_we",    64'(ld.imem_we),   64'd0);
    chk("rstld_state", 64'(state),        64'd0);
    chk("rstld_ready", 64'(ld.ld_ready),  64'd0);
    cyc();
    RST_N = 1'b1; ld.ld_valid = 1'b0;
    #1;
    chk("rstld_idle",   64'(state),                 64'd0);
    chk("rstld_cnt",    64'(cycle_cnt),             64'd0);
    chk("rstld_writes", 64'(wr_addr.size() - wr0), 64'd0);

    // Stop outranks run in IDLE; stop kills cpu_en at once in RUN.
    cmd_stop = 1'b1; cmd_run = 1'b1; cyc(); cmd_stop = 1'b0; cmd_run = 1'b0;
    #1 chk("stoprun_idle", 64'(state), 64'd0);
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    #1;
    chk("run2_state", 64'(state),  64'd2);
    chk("run2_en",    64'(cpu_en), 64'd1);
    cyc();
    cmd_stop = 1'b1;
    #1 chk("stop_en", 64'(cpu_en), 64'd0);
    cyc();
    cmd_stop = 1'b0;
    #1;
    chk("stop_idle", 64'(state),     64'd0);
    chk("stop_cnt",  64'(cycle_cnt), 64'd1);

`ifdef RUN_CTRL_BREAKPOINT_EN
    do_load("load3");
    bp_valid = 1'b1; bp_addr = 16'd2;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    for (int i = 0; i < 20 && state == 3'd2; i++) cyc();
    #1;
    chk("bp_idle", 64'(state),     64'd0);
    chk("bp_cnt",  64'(cycle_cnt), 64'd2);
    chk("bp_pc",   64'(pc),        64'd2);
    chk("bp_hits", 64'(bp_cnt),    64'd1);
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    for (int i = 0; i < 20 && state == 3'd2; i++) cyc();
    #1;
    chk("bp_rerun_halt", 64'(state),     64'd4);
    chk("bp_rerun_cnt",  64'(cycle_cnt), 64'd3);
    chk("bp_rerun_hits", 64'(bp_cnt),    64'd1);
    bp_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
